// File: rtl/weight_load_sched_pkg.sv
// weight_load_sched_pkg
//   Shared types and constants for the weight-store load sequencer:
//   sequencer state encoding, layer codes driven on cs, field widths and
//   the layer-order helper.
package weight_load_sched_pkg;

  localparam int unsigned CS_W    = 4;
  localparam int unsigned PHASE_W = 3;
  localparam int unsigned WAIT_W  = 5;

  // Sequencer states (3-bit encoding).
  typedef enum logic [2:0] {
    WS_IDLE  = 3'd0,
    WS_GAP   = 3'd1,
    WS_LOAD  = 3'd2,
    WS_READY = 3'd3,
    WS_FIN   = 3'd4
  } ws_state_e;

  // Layer codes presented on cs to every weight_store.
  typedef enum logic [CS_W-1:0] {
    LAYER0 = 4'd0,
    LAYER1 = 4'd1,
    LAYER2 = 4'd2,
    LAYER3 = 4'd3,
    AFFINE = 4'd4
  } layer_e;

  // Sweep order: LAYER0 -> LAYER1 -> LAYER2 -> LAYER3 -> AFFINE.
  function automatic layer_e next_layer(input layer_e cur);
    layer_e nxt;
    case (cur)
      LAYER0:  nxt = LAYER1;
      LAYER1:  nxt = LAYER2;
      LAYER2:  nxt = LAYER3;
      LAYER3:  nxt = AFFINE;
      default: nxt = LAYER0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/weight_load_sched_step_cnt.sv
// ws_step_cnt
//   Layer/phase position counter for the weight sweep.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clear      : return to LAYER0 / phase 0
//     step       : advance one phase (wrapping into the next layer)
//     cs         : current layer code
//     phase      : current phase within the layer
//     last       : current position is the final phase of AFFINE
module ws_step_cnt
  import weight_load_sched_pkg::*;
#(
  parameter int unsigned N_PHASE_CONV   = 8,
  parameter int unsigned N_PHASE_AFFINE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               step,
  output logic [CS_W-1:0]    cs,
  output logic [PHASE_W-1:0] phase,
  output logic               last
);

  localparam logic [PHASE_W-1:0] CONV_MAX   = PHASE_W'(N_PHASE_CONV - 1);
  localparam logic [PHASE_W-1:0] AFFINE_MAX = PHASE_W'(N_PHASE_AFFINE - 1);

  layer_e             layer;
  logic [PHASE_W-1:0] phase_max;
  logic               phase_end;

  assign phase_max = (layer == AFFINE) ? AFFINE_MAX : CONV_MAX;
  assign phase_end = (phase == phase_max);
  assign last      = (layer == AFFINE) && phase_end;
  assign cs        = layer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer <= LAYER0;
      phase <= '0;
    end else if (clear) begin
      layer <= LAYER0;
      phase <= '0;
    end else if (step) begin
      if (phase_end) begin
        layer <= next_layer(layer);
        phase <= '0;
      end else begin
        phase <= phase + PHASE_W'(1);
      end
    end
  end

endmodule

// File: rtl/weight_load_sched.sv
// weight_load_sched
//   Walks every (layer, phase) pair, drives cs/phase/load to all
//   weight_store instances, waits for all stores to report valid and hands
//   each weight set to the datapath through a w_ready/w_ack handshake.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     start        : begin a full sweep (accepted only when idle)
//     store_valid  : per-store valid
//     store_load   : load to all stores
//     cs, phase    : current layer code / phase index
//     w_ready      : weights for (cs, phase) are on the store outputs
//     w_ack        : consumer is done with the current weights
//     busy         : sequencer not idle
//     done         : one-cycle pulse at the end of a sweep
//     err          : sticky valid-wait timeout flag
module weight_load_sched
  import weight_load_sched_pkg::*;
#(
  parameter int unsigned NUM_STORES     = 4,
  parameter int unsigned N_PHASE_CONV   = 8,
  parameter int unsigned N_PHASE_AFFINE = 2,
  parameter int unsigned TIMEOUT        = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_STORES-1:0] store_valid,
  output logic                  store_load,
  output logic [CS_W-1:0]       cs,
  output logic [PHASE_W-1:0]    phase,
  output logic                  w_ready,
  input  logic                  w_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  ws_state_e         state, state_next;
  logic              skip;
  logic [WAIT_W-1:0] wait_cnt;
  logic              step, clear, set_err, last;
  logic              all_valid;

  assign all_valid = &store_valid;

  ws_step_cnt #(
    .N_PHASE_CONV  (N_PHASE_CONV),
    .N_PHASE_AFFINE(N_PHASE_AFFINE)
  ) u_step_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .step (step),
    .cs   (cs),
    .phase(phase),
    .last (last)
  );

  always_comb begin
    state_next = state;
    step       = 1'b0;
    clear      = 1'b0;
    set_err    = 1'b0;
    case (state)
      WS_IDLE: begin
        if (start) begin
          state_next = WS_GAP;
          clear      = 1'b1;
        end
      end
      WS_GAP: state_next = WS_LOAD;
      WS_LOAD: begin
        // Valid seen in the first LOAD cycle belongs to the previous phase.
        if (!skip && all_valid) begin
          state_next = WS_READY;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = WS_FIN;
          set_err    = 1'b1;
        end
      end
      WS_READY: begin
        if (w_ack) begin
          if (last) begin
            state_next = WS_FIN;
          end else begin
            state_next = WS_GAP;
            step       = 1'b1;
          end
        end
      end
      WS_FIN:  state_next = WS_IDLE;
      default: state_next = WS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WS_IDLE;
      skip     <= 1'b0;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      skip     <= (state == WS_GAP);
      wait_cnt <= (state == WS_LOAD) ? wait_cnt + WAIT_W'(1) : '0;
      if (clear) begin
        err <= 1'b0;
      end else if (set_err) begin
        err <= 1'b1;
      end
    end
  end

  // Outputs are registered from the next state so they align with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_load <= 1'b0;
      w_ready    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      store_load <= (state_next == WS_LOAD) || (state_next == WS_READY);
      w_ready    <= (state_next == WS_READY);
      busy       <= (state_next != WS_IDLE);
      done       <= (state_next == WS_FIN);
    end
  end

endmodule

// File: tb/tb_weight_load_sched.sv
// tb_weight_load_sched
//   Directed bench for weight_load_sched with a store/consumer model and a
//   scoreboard of expected (cs, phase) handoffs.
module tb_weight_load_sched;

  localparam int unsigned NS    = 4;
  localparam int unsigned N_HS  = 34;
  localparam logic [3:0]  C_L2  = 4'd2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [NS-1:0] store_valid;
  logic          store_load;
  logic [3:0]    cs;
  logic [2:0]    phase;
  logic          w_ready;
  logic          w_ack;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] cs;
    logic [2:0] ph;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  weight_load_sched #(
    .NUM_STORES    (NS),
    .N_PHASE_CONV  (8),
    .N_PHASE_AFFINE(2),
    .TIMEOUT       (31)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .store_valid(store_valid),
    .store_load (store_load),
    .cs         (cs),
    .phase      (phase),
    .w_ready    (w_ready),
    .w_ack      (w_ack),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Store model: valid rises lat cycles after load rises; in stale mode the
  // previous valid is kept while load is low.
  int         lat = 5;
  bit         stale = 1'b0;
  logic [NS-1:0] dead_mask = '0;
  int         ld_cnt;
  logic       v;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt <= 0;
      v      <= 1'b0;
    end else if (!store_load) begin
      ld_cnt <= 0;
      if (!stale) v <= 1'b0;
    end else begin
      ld_cnt <= ld_cnt + 1;
      v      <= ((ld_cnt + 1) >= lat);
    end
  end

  assign store_valid = {NS{v}} & ~dead_mask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_sweep();
    exp_t e;
    sbq.delete();
    for (int l = 0; l < 5; l++) begin
      for (int p = 0; p < ((l < 4) ? 8 : 2); p++) begin
        e.cs = 4'(l);
        e.ph = 3'(p);
        sbq.push_back(e);
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_sweep(input bit hold_ack, input bit inject, input bit abort_mid,
                           input int exp_load, input int exp_ready);
    int   load_run = 0, ready_run = 0, low_run = 0, hs = 0, ready_age = 0;
    bit   done_seen = 1'b0, ack_now;
    exp_t e;
    push_sweep();
    pulse_start();
    chk("gap_busy", busy, 1);
    chk("gap_load", store_load, 0);
    chk("gap_err", err, 0);
    chk("gap_cs", cs, 0);
    chk("gap_phase", phase, 0);
    @(negedge clk);
    chk("first_load", store_load, 1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (abort_mid && store_load && !w_ready && cs == C_L2 && phase == 3'd3) begin
        rst_n = 1'b0;
        #1;
        chk("arst_load", store_load, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cs", cs, 0);
        chk("arst_phase", phase, 0);
        chk("arst_ready", w_ready, 0);
        chk("arst_done", done, 0);
        w_ack = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        return;
      end
      if (done) begin
        done_seen = 1'b1;
        chk("done_err", err, 0);
        chk("done_load", store_load, 0);
        break;
      end
      if (!store_load) begin
        low_run++;
      end else if (!w_ready) begin
        if (low_run > 0) begin
          chk("gap_len", low_run, 1);
          low_run = 0;
        end
        load_run++;
      end
      if (w_ready) ready_run++;
      ack_now = hold_ack ? 1'b1 : (w_ready && ready_age >= 1);
      if (inject && store_load && !w_ready) ack_now = 1'b1;
      start = inject && w_ready && ready_age == 0;
      w_ack = ack_now;
      if (w_ready && ack_now) begin
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("hs_cs", cs, e.cs);
          chk("hs_phase", phase, e.ph);
        end else begin
          chk("sb_underflow", sbq.size(), 1);
        end
        chk("load_cycles", load_run, exp_load);
        chk("ready_cycles", ready_run, exp_ready);
        load_run  = 0;
        ready_run = 0;
        ready_age = 0;
        hs++;
      end else if (w_ready) begin
        ready_age++;
      end
      @(negedge clk);
    end
    w_ack = 1'b0;
    start = 1'b0;
    chk("done_seen", done_seen, 1);
    chk("hs_count", hs, N_HS);
    chk("sb_empty", sbq.size(), 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic run_timeout();
    int nload = 0;
    bit done_seen = 1'b0;
    dead_mask = 4'b0100;
    pulse_start();
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (done) begin
        done_seen = 1'b1;
        break;
      end
      if (store_load) nload++;
      @(negedge clk);
    end
    chk("to_done", done_seen, 1);
    chk("to_load_cycles", nload, 31);
    chk("to_err", err, 1);
    chk("to_fin_load", store_load, 0);
    @(negedge clk);
    chk("to_idle_busy", busy, 0);
    chk("to_done_pulse", done, 0);
    @(negedge clk);
    chk("to_err_sticky", err, 1);
    dead_mask = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    w_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_load", store_load, 0);
    chk("rst_cs", cs, 0);
    chk("rst_phase", phase, 0);
    chk("rst_ready", w_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal sweep: valid latency 5, ack one cycle after w_ready.
    run_sweep(1'b0, 1'b0, 1'b0, 6, 2);

    // Stale valid left high from the previous phase.
    stale = 1'b1;
    run_sweep(1'b0, 1'b0, 1'b0, 6, 2);
    stale = 1'b0;
    repeat (2) @(negedge clk);

    // One store never becomes valid; next start must clear err.
    run_timeout();
    run_sweep(1'b0, 1'b0, 1'b0, 6, 2);

    // start during READY and w_ack during LOAD are ignored.
    run_sweep(1'b0, 1'b1, 1'b0, 6, 2);

    // Consumer holds w_ack high.
    lat = 2;
    run_sweep(1'b1, 1'b0, 1'b0, 3, 1);
    lat = 5;

    // Reset in the middle of LAYER2 phase 3, then restart.
    run_sweep(1'b0, 1'b0, 1'b1, 6, 2);
    repeat (2) @(negedge clk);
    run_sweep(1'b0, 1'b0, 1'b0, 6, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
